// File: rtl/bus_timer_responder_if.sv
// CPU-side register bus for bus_timer_responder: address, write strobe/data, read data, interrupt.
// Latency: none; the interface carries wires only.
// Backpressure: none; the bus is always accepted, so there is no ready signal.
interface bus_timer_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic [ADDR_W-1:0] address_i;
    logic              we_i;
    logic [DATA_W-1:0] data_i;
    logic [DATA_W-1:0] data_o;
    logic              irq_o;

    // CPU side drives address/strobe/data and observes read data and interrupt
    modport master (
        output address_i, we_i, data_i,
        input  data_o, irq_o
    );

    // Timer side consumes the access and returns read data and interrupt
    modport slave (
        input  address_i, we_i, data_i,
        output data_o, irq_o
    );
endinterface

// File: rtl/bus_timer_responder.sv
// Memory-mapped prescaled down-counter timer with level irq; optional COUNT capture (BUS_TIMER_CAPTURE_EN).
// Latency: writes land on the next edge; reads return registered data one cycle after the access.
// Backpressure: none; every access completes in a single cycle.
module bus_timer_responder #(
    parameter int              ADDR_W    = 32,
    parameter int              DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h0000_9000)
) (
    input  logic clk_i,
    input  logic reset_i,
`ifdef BUS_TIMER_CAPTURE_EN
    input  logic capture_i,
`endif
    bus_timer_responder_if.slave bus
);

    localparam logic [ADDR_W-1:0] LP_WIN_TOP = BASE_ADDR + ADDR_W'(32'h1F);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Architectural registers
    logic [2:0]        r_ctrl;      // {IRQ_EN, AUTO_RELOAD, EN}
    logic [15:0]       r_prescale;
    logic [DATA_W-1:0] r_load;
    logic [DATA_W-1:0] r_count;
    logic              r_pend;
    logic [15:0]       r_pcnt;      // prescale phase counter
    state_t            r_state;
    logic [DATA_W-1:0] r_data_o;
    logic              r_irq;

    // Decode and next-state wires
    logic              w_hit;
    logic [2:0]        w_off;
    logic              w_wr;
    logic              w_rd;
    logic              w_wr_ctrl;
    logic              w_wr_prescale;
    logic              w_wr_load;
    logic              w_wr_count;
    logic              w_wr_status;
    logic              w_tick;
    logic              w_expire;
    logic [2:0]        w_ctrl_nxt;
    logic [DATA_W-1:0] w_count_nxt;
    logic              w_pend_nxt;
    logic [15:0]       w_pcnt_nxt;
    logic [DATA_W-1:0] w_rd_dat;

    // Address window decode; the low two address bits never select anything
    always_comb begin
        w_hit         = (bus.address_i >= BASE_ADDR) && (bus.address_i <= LP_WIN_TOP);
        w_off         = bus.address_i[4:2];
        w_wr          = w_hit && bus.we_i;
        w_rd          = w_hit && !bus.we_i;
        w_wr_ctrl     = w_wr && (w_off == 3'd0);
        w_wr_prescale = w_wr && (w_off == 3'd1);
        w_wr_load     = w_wr && (w_off == 3'd2);
        w_wr_count    = w_wr && (w_off == 3'd3);
        w_wr_status   = w_wr && (w_off == 3'd4);
    end

    // Timer next-state: bus writes take priority over hardware updates, except PEND where set wins
    always_comb begin
        w_tick   = (r_state == ST_RUN) && (r_pcnt == r_prescale);
        w_expire = w_tick && (r_count == '0);

        w_ctrl_nxt = r_ctrl;
        if (w_expire && !r_ctrl[1]) begin
            w_ctrl_nxt[0] = 1'b0;
        end
        if (w_wr_ctrl) begin
            w_ctrl_nxt = bus.data_i[2:0];
        end

        w_count_nxt = r_count;
        if (w_wr_count) begin
            w_count_nxt = bus.data_i;
        end else if (w_tick) begin
            if (r_count != '0) begin
                w_count_nxt = r_count - DATA_W'(1);
            end else if (r_ctrl[1]) begin
                w_count_nxt = r_load;
            end
        end

        w_pend_nxt = w_expire || (r_pend && !(w_wr_status && bus.data_i[0]));

        // Phase restarts on COUNT/PRESCALE writes and whenever the timer is or becomes idle
        w_pcnt_nxt = '0;
        if (!w_wr_count && !w_wr_prescale && w_ctrl_nxt[0] &&
            (r_state == ST_RUN) && !w_tick) begin
            w_pcnt_nxt = r_pcnt + 16'd1;
        end
    end

`ifdef BUS_TIMER_CAPTURE_EN
    logic              r_cap_s1;
    logic              r_cap_s2;
    logic              r_cap_s3;
    logic [DATA_W-1:0] r_capture;

    // Two-flop synchroniser on capture_i, then latch the current (pre-update) COUNT on a rising edge
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_cap_s1  <= 1'b0;
            r_cap_s2  <= 1'b0;
            r_cap_s3  <= 1'b0;
            r_capture <= '0;
        end else begin
            r_cap_s1 <= capture_i;
            r_cap_s2 <= r_cap_s1;
            r_cap_s3 <= r_cap_s2;
            if (r_cap_s2 && !r_cap_s3) begin
                r_capture <= r_count;
            end
        end
    end
`endif

    // Read mux: zero outside the window, for writes, reserved offsets and unused upper bits
    always_comb begin
        w_rd_dat = '0;
        if (w_rd) begin
            case (w_off)
                3'd0:    w_rd_dat[2:0]  = r_ctrl;
                3'd1:    w_rd_dat[15:0] = r_prescale;
                3'd2:    w_rd_dat       = r_load;
                3'd3:    w_rd_dat       = r_count;
                3'd4:    w_rd_dat[1:0]  = {(r_state == ST_RUN), r_pend};
`ifdef BUS_TIMER_CAPTURE_EN
                3'd5:    w_rd_dat       = r_capture;
`endif
                default: w_rd_dat       = '0;
            endcase
        end
    end

    // Register file and prescale phase update
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_ctrl     <= '0;
            r_prescale <= '0;
            r_load     <= '0;
            r_count    <= '0;
            r_pend     <= 1'b0;
            r_pcnt     <= '0;
        end else begin
            r_ctrl  <= w_ctrl_nxt;
            r_count <= w_count_nxt;
            r_pend  <= w_pend_nxt;
            r_pcnt  <= w_pcnt_nxt;
            if (w_wr_prescale) begin
                r_prescale <= bus.data_i[15:0];
            end
            if (w_wr_load) begin
                r_load <= bus.data_i;
            end
        end
    end

    // Run/idle FSM follows the next EN value so counting starts the cycle after EN is written; drives registered outputs
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state  <= ST_IDLE;
            r_data_o <= '0;
            r_irq    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: if (w_ctrl_nxt[0])  r_state <= ST_RUN;
                ST_RUN:  if (!w_ctrl_nxt[0]) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
            r_data_o <= w_rd_dat;
            r_irq    <= w_pend_nxt && w_ctrl_nxt[2];
        end
    end

    assign bus.data_o = r_data_o;
    assign bus.irq_o  = r_irq;

endmodule
